// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared fetch types and redirect target computation
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_JR  = 2'd1,
    PC_J   = 2'd2,
    PC_BR  = 2'd3
  } pc_src_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

  // Branch offset is in words, so it is sign-extended and shifted by two.
  function automatic word_t redirect_target(
    input pc_src_t     src,
    input word_t       br_pc,
    input logic [15:0] imm,
    input word_t       jr_addr,
    input logic [3:0]  j_pc_hi,
    input logic [25:0] j_addr
  );
    word_t tgt;
    case (src)
      PC_JR:   tgt = jr_addr;
      PC_J:    tgt = {j_pc_hi, j_addr, 2'b00};
      PC_BR:   tgt = br_pc + {{14{imm[15]}}, imm, 2'b00};
      default: tgt = br_pc;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - imem request and decode-side queue handshake bundle
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  import cpu_types_pkg::*;

  logic             imemREN;
  word_t            imemaddr;
  logic             ihit;
  word_t            imemload;
  logic             out_valid;
  logic             out_ready;
  word_t            out_instr;
  word_t            out_pc;
  word_t            out_npc;
  logic [CNT_W-1:0] count;

  modport master (
    output imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, count,
    input  ihit, imemload, out_ready
  );

  modport slave (
    input  imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, count,
    output ihit, imemload, out_ready
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - fetch_fifo: DEPTH-entry {pc, instr} buffer with flush
module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full queue is legal then.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push & ~do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop & ~do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential imem fetch into a flushable queue; FETCH_PERF_EN adds perf counters
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0,
  parameter int    DEPTH   = 4,
  parameter int    CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic        CLK,
  input  logic        nRST,
  fetch_queue_if.master bus,
  input  logic        halt,
  input  logic        redir,
  input  logic [1:0]  redir_src,
  input  word_t       brPC,
  input  logic [15:0] imm,
  input  word_t       jraddr,
  input  word_t       jPC,
  input  logic [25:0] jaddr
`ifdef FETCH_PERF_EN
  ,
  output word_t       stall_cycles,
  output word_t       flush_count,
  output word_t       fetched_count
`endif
);

  word_t            pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             redir_eff, ren, push, pop;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head;
  word_t            target;
  logic             unused_jpc;

  assign unused_jpc = ^jPC[27:0];

  assign redir_eff = redir & (pc_src_t'(redir_src) != PC_SEQ);
  assign target    = redirect_target(pc_src_t'(redir_src), brPC, imm, jraddr, jPC[31:28], jaddr);

  // Request is held off while in reset so imem never sees a stray read.
  assign ren  = nRST & ~halted_q & ~redir_eff & ~fifo_full;
  assign push = ren & bus.ihit;
  assign pop  = ~fifo_empty & bus.out_ready;

  assign bus.imemREN   = ren;
  assign bus.imemaddr  = pc_q;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.out_npc   = head.pc + PC_STEP;
  assign bus.count     = fifo_count;

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q | halt;
    if (redir_eff)  pc_d = target;
    else if (push)  pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= PC_INIT;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .push_i      (push),
    .push_data_i ('{pc: pc_q, instr: bus.imemload}),
    .pop_i       (pop),
    .flush_i     (redir_eff),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

`ifdef FETCH_PERF_EN
  word_t stall_q, stall_d;
  word_t flush_q, flush_d;
  word_t fetched_q, fetched_d;

  always_comb begin
    stall_d   = stall_q;
    flush_d   = flush_q;
    fetched_d = fetched_q;
    if (ren & ~bus.ihit & (stall_q != '1))  stall_d   = stall_q + 32'd1;
    if (redir_eff & (flush_q != '1))        flush_d   = flush_q + 32'd1;
    if (push & (fetched_q != '1))           fetched_d = fetched_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q   <= '0;
      flush_q   <= '0;
      fetched_q <= '0;
    end else begin
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      fetched_q <= fetched_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign fetched_count = fetched_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based model
`timescale 1ns/1ps
module tb_fetch_queue;
  import cpu_types_pkg::*;

  localparam int          DEPTH   = 4;
  localparam int          CNT_W   = $clog2(DEPTH + 1);
  localparam logic [31:0] PC_INIT = 32'h0;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        redir = 1'b0;
  logic [1:0]  redir_src = 2'd0;
  logic [31:0] brPC = '0, jraddr = '0, jPC = '0;
  logic [15:0] imm = '0;
  logic [25:0] jaddr = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles, flush_count, fetched_count;
`endif

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .halt      (halt),
    .redir     (redir),
    .redir_src (redir_src),
    .brPC      (brPC),
    .imm       (imm),
    .jraddr    (jraddr),
    .jPC       (jPC),
    .jaddr     (jaddr)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .fetched_count (fetched_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_halted;
  int          m_stall, m_flush, m_fetch;
  int          checks = 0;
  int          failures = 0;

  function automatic bit m_redir();
    return redir && (redir_src != 2'd0);
  endfunction

  function automatic logic [31:0] m_target();
    int off;
    off = int'($signed(imm));
    case (redir_src)
      2'd1:    return jraddr;
      2'd2:    return {jPC[31:28], jaddr, 2'b00};
      default: return brPC + 32'(off * 4);
    endcase
  endfunction

  function automatic bit exp_ren();
    return nRST && !m_halted && !m_redir() && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = PC_INIT;
    m_halted = 0;
    m_stall  = 0;
    m_flush  = 0;
    m_fetch  = 0;
  endtask

  task automatic model_step();
    bit pop, push;
    pop  = (m_q.size() > 0) && bus.out_ready;
    push = exp_ren() && bus.ihit;
    if (exp_ren() && !bus.ihit) m_stall++;
    if (m_redir()) begin
      m_pc = m_target();
      m_q.delete();
      m_flush++;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{m_pc, bus.imemload});
        m_pc += 32'd4;
        m_fetch++;
      end
    end
    if (halt) m_halted = 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    halt = 0; redir = 0; redir_src = 0;
    brPC = 0; imm = 0; jraddr = 0; jPC = 0; jaddr = 0;
    bus.ihit = 0; bus.imemload = 0; bus.out_ready = 0;
    @(posedge CLK);
    #1;
    model_reset();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.ihit = 0; bus.out_ready = 0; bus.imemload = 0;
    #2;
    checks++; if (bus.imemREN !== 1'b0) begin failures++; $display("FAIL reset_ren got=%b exp=0", bus.imemREN); end
    checks++; if (bus.count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imemaddr !== PC_INIT) begin failures++; $display("FAIL reset_addr got=%h exp=%h", bus.imemaddr, PC_INIT); end
    do_reset();
    @(negedge CLK);
    checks++; if (bus.imemREN !== 1'b1) begin failures++; $display("FAIL reset_release_ren got=%b exp=1", bus.imemREN); end
  endtask

  task automatic test_sequential();
    do_reset();
    bus.ihit = 1; bus.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      bus.imemload = 32'hC0DE0000 | i;
      @(negedge CLK);
      checks++; if (bus.imemaddr !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr i=%0d got=%h exp=%h", i, bus.imemaddr, 4 * i); end
      if (i > 0) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL seq_valid i=%0d got=%b exp=1", i, bus.out_valid); end
        checks++; if (bus.out_pc !== 32'(4 * (i - 1))) begin failures++; $display("FAIL seq_pc i=%0d got=%h exp=%h", i, bus.out_pc, 4 * (i - 1)); end
        checks++; if (bus.out_npc !== 32'(4 * i)) begin failures++; $display("FAIL seq_npc i=%0d got=%h exp=%h", i, bus.out_npc, 4 * i); end
        checks++; if (bus.out_instr !== (32'hC0DE0000 | (i - 1))) begin failures++; $display("FAIL seq_instr i=%0d got=%h exp=%h", i, bus.out_instr, 32'hC0DE0000 | (i - 1)); end
      end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.ihit = 1; bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.imemload = 32'h10000000 + i;
      tick();
    end
    @(negedge CLK);
    checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", bus.count); end
    checks++; if (bus.imemREN !== 1'b0) begin failures++; $display("FAIL full_ren got=%b exp=0", bus.imemREN); end
    checks++; if (bus.imemaddr !== 32'd16) begin failures++; $display("FAIL full_addr got=%h exp=10", bus.imemaddr); end
    checks++; if (bus.out_pc !== 32'd0) begin failures++; $display("FAIL full_head got=%h exp=0", bus.out_pc); end
    bus.out_ready = 1;
    tick();
    @(negedge CLK);
    checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL full_pop_count got=%0d exp=3", bus.count); end
    checks++; if (bus.imemREN !== 1'b1) begin failures++; $display("FAIL full_resume_ren got=%b exp=1", bus.imemREN); end
    checks++; if (bus.imemaddr !== 32'd16) begin failures++; $display("FAIL full_resume_addr got=%h exp=10", bus.imemaddr); end
    checks++; if (bus.out_pc !== 32'd4) begin failures++; $display("FAIL full_pop_head got=%h exp=4", bus.out_pc); end
    tick();
    @(negedge CLK);
    checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL pushpop_count got=%0d exp=3", bus.count); end
    checks++; if (bus.out_pc !== 32'd8) begin failures++; $display("FAIL pushpop_head got=%h exp=8", bus.out_pc); end
    checks++; if (bus.imemaddr !== 32'd20) begin failures++; $display("FAIL pushpop_addr got=%h exp=14", bus.imemaddr); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.ihit = 1; bus.out_ready = 0;
    tick();
    tick();
    redir = 1; redir_src = 2'd3; brPC = 32'h100; imm = 16'hFFFE;
    @(negedge CLK);
    checks++; if (bus.imemREN !== 1'b0) begin failures++; $display("FAIL br_ren got=%b exp=0", bus.imemREN); end
    tick();
    redir = 0; bus.ihit = 0;
    @(negedge CLK);
    checks++; if (bus.imemaddr !== 32'hF8) begin failures++; $display("FAIL br_target got=%h exp=f8", bus.imemaddr); end
    checks++; if (bus.count !== '0) begin failures++; $display("FAIL br_flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL br_flush_valid got=%b exp=0", bus.out_valid); end
    redir = 1; redir_src = 2'd1; jraddr = 32'h4000;
    tick();
    redir = 0;
    @(negedge CLK);
    checks++; if (bus.imemaddr !== 32'h4000) begin failures++; $display("FAIL jr_target got=%h exp=4000", bus.imemaddr); end
    redir = 1; redir_src = 2'd2; jPC = 32'hA0000010; jaddr = 26'h0000040;
    tick();
    redir = 0;
    @(negedge CLK);
    checks++; if (bus.imemaddr !== 32'hA0000100) begin failures++; $display("FAIL j_target got=%h exp=a0000100", bus.imemaddr); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    bus.ihit = 1; bus.out_ready = 0;
    tick();
    bus.ihit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (bus.imemREN !== 1'b1) begin failures++; $display("FAIL stall_ren i=%0d got=%b exp=1", i, bus.imemREN); end
      checks++; if (bus.imemaddr !== 32'd4) begin failures++; $display("FAIL stall_addr i=%0d got=%h exp=4", i, bus.imemaddr); end
      tick();
    end
    @(negedge CLK);
`ifdef FETCH_PERF_EN
    checks++; if (stall_cycles !== 32'd3) begin failures++; $display("FAIL stall_cycles got=%0d exp=3", stall_cycles); end
`endif
    nRST = 1'b0;
    #1;
    checks++; if (bus.imemaddr !== PC_INIT) begin failures++; $display("FAIL midreset_addr got=%h exp=%h", bus.imemaddr, PC_INIT); end
    checks++; if (bus.count !== '0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", bus.out_valid); end
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic test_halt();
    do_reset();
    bus.ihit = 1; bus.out_ready = 0;
    tick();
    tick();
    halt = 1; bus.ihit = 0;
    tick();
    halt = 0; bus.ihit = 1; bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (bus.imemREN !== 1'b0) begin failures++; $display("FAIL halt_ren i=%0d got=%b exp=0", i, bus.imemREN); end
      if (i < 2) begin
        checks++; if (bus.out_pc !== 32'(4 * i) || bus.out_valid !== 1'b1) begin failures++; $display("FAIL halt_drain i=%0d got=%h/%b exp=%h/1", i, bus.out_pc, bus.out_valid, 4 * i); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL halt_empty got=%b exp=0", bus.out_valid); end
      end
      tick();
    end
    redir = 1; redir_src = 2'd1; jraddr = 32'h200;
    tick();
    redir = 0;
    @(negedge CLK);
    checks++; if (bus.imemaddr !== 32'h200) begin failures++; $display("FAIL halt_redir_addr got=%h exp=200", bus.imemaddr); end
    checks++; if (bus.imemREN !== 1'b0) begin failures++; $display("FAIL halt_redir_ren got=%b exp=0", bus.imemREN); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.ihit      = ($urandom % 4) != 0;
      bus.out_ready = $urandom % 2;
      bus.imemload  = $urandom;
      redir         = ($urandom % 12) == 0;
      redir_src     = 2'($urandom % 4);
      brPC          = $urandom;
      imm           = 16'($urandom);
      jraddr        = $urandom;
      jPC           = $urandom;
      jaddr         = 26'($urandom);
      halt          = (c == 350);
      @(negedge CLK);
      checks++; if (bus.imemREN !== exp_ren()) begin failures++; $display("FAIL rand_ren c=%0d got=%b exp=%b", c, bus.imemREN, exp_ren()); end
      checks++; if (bus.imemaddr !== m_pc) begin failures++; $display("FAIL rand_addr c=%0d got=%h exp=%h", c, bus.imemaddr, m_pc); end
      checks++; if (bus.count !== CNT_W'(m_q.size())) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, bus.count, m_q.size()); end
      checks++; if (bus.out_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++;
        if (bus.out_pc !== m_q[0].pc || bus.out_instr !== m_q[0].instr || bus.out_npc !== m_q[0].pc + 32'd4) begin
          failures++;
          $display("FAIL rand_head c=%0d got=%h/%h/%h exp=%h/%h/%h", c, bus.out_pc, bus.out_instr, bus.out_npc, m_q[0].pc, m_q[0].instr, m_q[0].pc + 32'd4);
        end
      end
      tick();
    end
    halt = 0; redir = 0;
`ifdef FETCH_PERF_EN
    @(negedge CLK);
    checks++; if (stall_cycles !== 32'(m_stall)) begin failures++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cycles, m_stall); end
    checks++; if (flush_count !== 32'(m_flush)) begin failures++; $display("FAIL perf_flush got=%0d exp=%0d", flush_count, m_flush); end
    checks++; if (fetched_count !== 32'(m_fetch)) begin failures++; $display("FAIL perf_fetched got=%0d exp=%0d", fetched_count, m_fetch); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_full();
    test_redirect();
    test_stall_reset();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
